// File: rtl/regfile_pair.sv
// regfile_pair: dual-read byte/pair register file with an in-place INC/DEC/INC2 pair unit.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write/pair_op results to both read ports.
module regfile_pair #(
   parameter int DATA_W = 8,
   parameter int NREGS  = 12,
   parameter int AW     = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic                wr_pair,
   input  logic [AW-1:0]       wr_sel,
   input  logic [2*DATA_W-1:0] wr_data,
   input  logic [1:0]          pair_op,
   input  logic [AW-1:0]       pair_sel,
   input  logic [AW-1:0]       rd_sel_a,
   input  logic [AW-1:0]       rd_sel_b,
   input  logic                rd_pair_a,
   input  logic                rd_pair_b,
   output logic [2*DATA_W-1:0] rd_data_a,
   output logic [2*DATA_W-1:0] rd_data_b,
   output logic                pair_zero,
   output logic                pair_carry,
   output logic                addr_err
);

   localparam int PW = 2 * DATA_W;

   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_INC  = 2'b01;
   localparam logic [1:0] OP_DEC  = 2'b10;
   localparam logic [1:0] OP_INC2 = 2'b11;

   typedef logic [DATA_W-1:0] bank_t [NREGS];

   function automatic logic sel_ok(input logic [AW-1:0] sel, input logic pair);
      int last;
      last = int'(sel) + int'(pair);
      return (last < NREGS);
   endfunction

   // Byte reads zero-extend; pair reads are {r[i], r[i+1]}; out-of-range reads yield zero.
   function automatic logic [PW-1:0] read_word(input bank_t bank, input logic [AW-1:0] sel,
                                               input logic pair);
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] lo;
      logic [PW-1:0]     word;
      hi = '0;
      lo = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (int'(sel) == i) begin
            hi = bank[i];
         end
         if (int'(sel) + 32'sd1 == i) begin
            lo = bank[i];
         end
      end
      if (!sel_ok(sel, pair)) begin
         word = '0;
      end else if (pair) begin
         word = {hi, lo};
      end else begin
         word = {{DATA_W{1'b0}}, hi};
      end
      return word;
   endfunction

   bank_t         regs_r;
   bank_t         regs_nxt_s;
   bank_t         rd_src_s;
   logic [PW-1:0] op_src_s;
   logic [PW:0]   op_sum_s;
   logic [PW-1:0] op_res_s;
   logic          op_carry_s;
   logic          wr_ok_s;
   logic          op_ok_s;
   logic          err_s;

   // Legality of this cycle's write, pair_op and reads.
   always_comb begin
      wr_ok_s = wr_en && sel_ok(wr_sel, wr_pair);
      op_ok_s = (pair_op != OP_NONE) && sel_ok(pair_sel, 1'b1);
      err_s   = (wr_en && !sel_ok(wr_sel, wr_pair))
             || ((pair_op != OP_NONE) && !sel_ok(pair_sel, 1'b1))
             || !sel_ok(rd_sel_a, rd_pair_a)
             || !sel_ok(rd_sel_b, rd_pair_b);
   end

   // Pair arithmetic; the extra top bit carries out of INC/INC2 and borrows on DEC.
   always_comb begin
      op_src_s = read_word(regs_r, pair_sel, 1'b1);
      case (pair_op)
         OP_INC:  op_sum_s = {1'b0, op_src_s} + {{PW{1'b0}}, 1'b1};
         OP_DEC:  op_sum_s = {1'b0, op_src_s} - {{PW{1'b0}}, 1'b1};
         OP_INC2: op_sum_s = {1'b0, op_src_s} + {{(PW-1){1'b0}}, 2'b10};
         default: op_sum_s = {1'b0, op_src_s};
      endcase
      op_res_s   = op_sum_s[PW-1:0];
      op_carry_s = op_sum_s[PW];
   end

   // Next register contents: pair_op bytes take priority over write bytes.
   always_comb begin
      regs_nxt_s = regs_r;
      for (int i = 0; i < NREGS; i++) begin
         if (op_ok_s && int'(pair_sel) == i) begin
            regs_nxt_s[i] = op_res_s[PW-1:DATA_W];
         end else if (op_ok_s && int'(pair_sel) + 32'sd1 == i) begin
            regs_nxt_s[i] = op_res_s[DATA_W-1:0];
         end else if (wr_ok_s && int'(wr_sel) == i) begin
            regs_nxt_s[i] = wr_pair ? wr_data[PW-1:DATA_W] : wr_data[DATA_W-1:0];
         end else if (wr_ok_s && wr_pair && int'(wr_sel) + 32'sd1 == i) begin
            regs_nxt_s[i] = wr_data[DATA_W-1:0];
         end else begin
            regs_nxt_s[i] = regs_r[i];
         end
      end
   end

   // Read source: forwarded post-update contents or the stored array.
   always_comb begin
`ifdef REGFILE_BYPASS_EN
      rd_src_s = regs_nxt_s;
`else
      rd_src_s = regs_r;
`endif
   end

   // State, registered read data and flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regs_r     <= '{default: '0};
         rd_data_a  <= '0;
         rd_data_b  <= '0;
         pair_zero  <= 1'b0;
         pair_carry <= 1'b0;
         addr_err   <= 1'b0;
      end else begin
         regs_r    <= regs_nxt_s;
         rd_data_a <= read_word(rd_src_s, rd_sel_a, rd_pair_a);
         rd_data_b <= read_word(rd_src_s, rd_sel_b, rd_pair_b);
         addr_err  <= err_s;
         if (op_ok_s) begin
            pair_zero  <= (op_res_s == '0);
            pair_carry <= op_carry_s;
         end
      end
   end

endmodule

// File: tb/tb_regfile_pair.sv
// Self-checking bench for regfile_pair: directed scenarios plus randomized traffic
// compared against an integer-array reference model (honours REGFILE_BYPASS_EN).
module tb_regfile_pair;

   localparam int DATA_W = 8;
   localparam int NREGS  = 12;
   localparam int AW     = $clog2(NREGS);
   localparam int PW     = 2 * DATA_W;
   localparam int BMOD   = 1 << DATA_W;
   localparam int PMOD   = BMOD * BMOD;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic          wr_pair;
   logic [AW-1:0] wr_sel;
   logic [PW-1:0] wr_data;
   logic [1:0]    pair_op;
   logic [AW-1:0] pair_sel;
   logic [AW-1:0] rd_sel_a;
   logic [AW-1:0] rd_sel_b;
   logic          rd_pair_a;
   logic          rd_pair_b;
   logic [PW-1:0] rd_data_a;
   logic [PW-1:0] rd_data_b;
   logic          pair_zero;
   logic          pair_carry;
   logic          addr_err;

   int checks   = 0;
   int failures = 0;
   int m [NREGS];
   bit mz, mc;

   always #5 clk = ~clk;

   regfile_pair #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_pair(wr_pair), .wr_sel(wr_sel),
      .wr_data(wr_data), .pair_op(pair_op), .pair_sel(pair_sel),
      .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .rd_pair_a(rd_pair_a), .rd_pair_b(rd_pair_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .pair_zero(pair_zero),
      .pair_carry(pair_carry), .addr_err(addr_err)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // Reference read: -1 flags an out-of-range access.
   function automatic int model_rd(input int bank [NREGS], input int sel, input bit pair);
      if (sel + int'(pair) >= NREGS) return -1;
      if (pair) return bank[sel] * BMOD + bank[sel+1];
      return bank[sel];
   endfunction

   task automatic idle();
      wr_en = 1'b0; wr_pair = 1'b0; wr_sel = '0; wr_data = '0;
      pair_op = 2'd0; pair_sel = '0;
      rd_sel_a = '0; rd_sel_b = '0; rd_pair_a = 1'b0; rd_pair_b = 1'b0;
   endtask

   // Apply current inputs for one clock, predict results, compare after the edge.
   task automatic step(input string tag);
      int post [NREGS];
      int src  [NREGS];
      int ws, ps, v, r, ea, eb;
      bit err;
      ws = int'(wr_sel);
      ps = int'(pair_sel);
      post = m;
      err = 1'b0;
      if (wr_en) begin
         if (ws + int'(wr_pair) < NREGS) begin
            if (wr_pair) begin
               post[ws]   = int'(wr_data) / BMOD;
               post[ws+1] = int'(wr_data) % BMOD;
            end else begin
               post[ws] = int'(wr_data) % BMOD;
            end
         end else begin
            err = 1'b1;
         end
      end
      if (pair_op != 2'd0) begin
         if (ps + 1 < NREGS) begin
            v = m[ps] * BMOD + m[ps+1];
            case (pair_op)
               2'd1:    r = v + 1;
               2'd2:    r = v - 1;
               default: r = v + 2;
            endcase
            mc = (r < 0) || (r >= PMOD);
            r  = (r + PMOD) % PMOD;
            mz = (r == 0);
            post[ps]   = r / BMOD;
            post[ps+1] = r % BMOD;
         end else begin
            err = 1'b1;
         end
      end
`ifdef REGFILE_BYPASS_EN
      src = post;
`else
      src = m;
`endif
      ea = model_rd(src, int'(rd_sel_a), rd_pair_a);
      eb = model_rd(src, int'(rd_sel_b), rd_pair_b);
      if (ea < 0) begin err = 1'b1; ea = 0; end
      if (eb < 0) begin err = 1'b1; eb = 0; end
      @(posedge clk);
      #1;
      check_val({tag, "_rda"}, 32'(rd_data_a), ea);
      check_val({tag, "_rdb"}, 32'(rd_data_b), eb);
      check_val({tag, "_zero"}, 32'(pair_zero), 32'(mz));
      check_val({tag, "_carry"}, 32'(pair_carry), 32'(mc));
      check_val({tag, "_err"}, 32'(addr_err), 32'(err));
      m = post;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_rda"}, 32'(rd_data_a), 32'h0);
      check_val({tag, "_rdb"}, 32'(rd_data_b), 32'h0);
      check_val({tag, "_zero"}, 32'(pair_zero), 32'h0);
      check_val({tag, "_carry"}, 32'(pair_carry), 32'h0);
      check_val({tag, "_err"}, 32'(addr_err), 32'h0);
   endtask

   task automatic pair_wr(input int sel, input logic [PW-1:0] data);
      idle();
      wr_en = 1'b1; wr_pair = 1'b1; wr_sel = AW'(sel); wr_data = data;
      step("pwr");
   endtask

   task automatic pair_rd(input int sel_a, input bit pa, input int sel_b, input bit pb);
      idle();
      rd_sel_a = AW'(sel_a); rd_pair_a = pa; rd_sel_b = AW'(sel_b); rd_pair_b = pb;
      step("rd");
   endtask

   function automatic logic [AW-1:0] rand_sel();
      if ($urandom_range(0, 15) == 0) return AW'($urandom_range(NREGS - 1, (1 << AW) - 1));
      return AW'($urandom_range(0, NREGS - 2));
   endfunction

   function automatic logic [DATA_W-1:0] rand_byte();
      int k;
      k = int'($urandom_range(0, 5));
      if (k == 0) return 8'hFF;
      if (k == 1) return 8'h00;
      return 8'($urandom);
   endfunction

   initial begin
      for (int i = 0; i < NREGS; i++) m[i] = 0;
      mz = 1'b0; mc = 1'b0;
      idle();
      rst = 1'b1;
      #2 rst = 1'b0;
      #1 check_all_zero("por");
      @(negedge clk) rst = 1'b1;

      // Preload, then set flags and addr_err so the mid-cycle reset has something to clear.
      for (int i = 0; i < NREGS; i += 2) pair_wr(i, 16'($urandom) | 16'h0101);
      pair_wr(4, 16'hFFFF);
      idle();
      pair_op = 2'd1; pair_sel = AW'(4); rd_sel_a = AW'(0); rd_pair_a = 1'b1; rd_sel_b = AW'(15);
      step("prerst");
      #2 rst = 1'b0;
      #1 check_all_zero("rst_async");
      for (int i = 0; i < NREGS; i++) m[i] = 0;
      mz = 1'b0; mc = 1'b0;
      wr_en = 1'b1; wr_pair = 1'b1; wr_sel = AW'(2); wr_data = 16'h1234; pair_op = 2'd1;
      @(posedge clk);
      #1 check_all_zero("rst_hold");
      idle();
      @(negedge clk) rst = 1'b1;
      for (int i = 0; i < NREGS - 1; i += 2) begin
         pair_rd(i, 1'b1, i + 1, 1'b1);
         check_val("rst_regs", 32'(rd_data_a), 32'h0);
      end

      // Pair write then byte + pair reads.
      pair_wr(2, 16'hBEEF);
      pair_rd(3, 1'b0, 2, 1'b1);
      check_val("beef_byte", 32'(rd_data_a), 32'h00EF);
      check_val("beef_pair", 32'(rd_data_b), 32'hBEEF);

      // INC wrap, DEC borrow, INC2.
      pair_wr(4, 16'hFFFF);
      idle(); pair_op = 2'd1; pair_sel = AW'(4); step("inc");
      check_val("inc_zero", 32'(pair_zero), 32'h1);
      check_val("inc_carry", 32'(pair_carry), 32'h1);
      pair_rd(4, 1'b1, 5, 1'b0);
      check_val("inc_val", 32'(rd_data_a), 32'h0000);
      idle(); pair_op = 2'd2; pair_sel = AW'(4); step("dec");
      check_val("dec_zero", 32'(pair_zero), 32'h0);
      check_val("dec_carry", 32'(pair_carry), 32'h1);
      pair_rd(4, 1'b1, 4, 1'b1);
      check_val("dec_val", 32'(rd_data_a), 32'hFFFF);
      pair_wr(4, 16'h1234);
      idle(); pair_op = 2'd3; pair_sel = AW'(4); step("inc2");
      check_val("inc2_flags", {30'd0, pair_zero, pair_carry}, 32'h0);
      pair_rd(4, 1'b1, 4, 1'b1);
      check_val("inc2_val", 32'(rd_data_b), 32'h1236);

      // Write and pair_op together: overlapping byte goes to pair_op.
      pair_wr(2, 16'h10FF);
      idle(); wr_en = 1'b1; wr_sel = AW'(3); wr_data = 16'h0055; pair_op = 2'd1; pair_sel = AW'(2);
      step("ovl");
      pair_rd(2, 1'b1, 3, 1'b0);
      check_val("ovl_pair", 32'(rd_data_a), 32'h1100);
      idle(); wr_en = 1'b1; wr_sel = AW'(7); wr_data = 16'h0055; pair_op = 2'd1; pair_sel = AW'(2);
      step("disj");
      pair_rd(7, 1'b0, 2, 1'b1);
      check_val("disj_byte", 32'(rd_data_a), 32'h0055);
      check_val("disj_pair", 32'(rd_data_b), 32'h1101);

      // Out-of-range accesses: nothing changes, flags hold, one-cycle addr_err.
      pair_wr(8, 16'hFFFF);
      idle(); pair_op = 2'd1; pair_sel = AW'(8); step("preoor");
      idle();
      pair_op = 2'd1; pair_sel = AW'(11); rd_sel_a = AW'(11); rd_pair_a = 1'b1;
      wr_en = 1'b1; wr_sel = AW'(12); wr_data = 16'h00AA;
      step("oor");
      check_val("oor_rd", 32'(rd_data_a), 32'h0);
      check_val("oor_err", 32'(addr_err), 32'h1);
      check_val("oor_flags", {30'd0, pair_zero, pair_carry}, 32'h3);
      pair_rd(10, 1'b1, 11, 1'b0);
      check_val("oor_clr", 32'(addr_err), 32'h0);

      // Same-cycle read of a pair being written.
      pair_wr(6, 16'h1111);
      idle(); wr_en = 1'b1; wr_pair = 1'b1; wr_sel = AW'(6); wr_data = 16'hA5A5;
      rd_sel_a = AW'(6); rd_pair_a = 1'b1;
      step("byp");
`ifdef REGFILE_BYPASS_EN
      check_val("byp_val", 32'(rd_data_a), 32'hA5A5);
`else
      check_val("byp_val", 32'(rd_data_a), 32'h1111);
`endif

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         wr_en     = ($urandom_range(0, 1) == 1);
         wr_pair   = ($urandom_range(0, 1) == 1);
         wr_sel    = rand_sel();
         wr_data   = {rand_byte(), rand_byte()};
         pair_op   = 2'($urandom_range(0, 3));
         pair_sel  = rand_sel();
         rd_sel_a  = rand_sel();
         rd_sel_b  = rand_sel();
         rd_pair_a = ($urandom_range(0, 1) == 1);
         rd_pair_b = ($urandom_range(0, 1) == 1);
         step("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
